vga_pixel_fetch: RTL and testbench

- Downstream stage of the VGA sync generator. Consumes its next_pixel_h/next_pixel_v coordinates and its blank_n/HS/VS timing.
- Generates read addresses into an external synchronous framebuffer RAM, or substitutes an internal test pattern.
- Delays all timing signals so RGB, blank, HS and VS leave the block aligned on the same vga_clk edge. Output drives the DAC/pins directly.

---
 rtl/vga_pixel_fetch.sv | 190 +++++++++++++++++++
 tb/tb_vga_pixel_fetch.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_fetch.sv
// Pixel fetch stage behind the VGA sync generator: framebuffer addressing,
// built-in test patterns and timing alignment of colour with blank/HS/VS.
module vga_pixel_fetch #(
    parameter int H_VISIBLE   = 800,
    parameter int V_VISIBLE   = 480,
    parameter int ADDR_W      = 19,
    parameter int MEM_LATENCY = 2,
    parameter int COLOR_W     = 8
) (
    input  logic                   vga_clk,
    input  logic                   reset,
    input  logic [10:0]            pixel_h,
    input  logic [10:0]            pixel_v,
    input  logic                   blank_n_in,
    input  logic                   hs_in,
    input  logic                   vs_in,
    input  logic [1:0]             pattern_sel,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic                   mem_rd,
    input  logic [3*COLOR_W-1:0]   mem_data,
    output logic [COLOR_W-1:0]     vga_r,
    output logic [COLOR_W-1:0]     vga_g,
    output logic [COLOR_W-1:0]     vga_b,
    output logic                   vga_blank_n,
    output logic                   vga_hs,
    output logic                   vga_vs,
    output logic                   frame_start
);

    localparam int L     = MEM_LATENCY + 1;
    localparam int RGB_W = 3 * COLOR_W;
    localparam int BAR_W = H_VISIBLE / 8;
    localparam int CNT_W = $clog2(H_VISIBLE + 1);

    localparam logic [10:0]       H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0]       V_VIS    = 11'(V_VISIBLE);
    localparam logic [ADDR_W-1:0] H_STRIDE = ADDR_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0]  BAR_LAST = CNT_W'(BAR_W - 1);

    typedef enum logic [1:0] {
        MODE_FB    = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_WHITE = 2'd3
    } mode_t;

    mode_t              active_sel;
    logic [10:0]        v_prev;
    logic [ADDR_W-1:0]  line_base;
    logic [2:0]         bar_idx;
    logic [CNT_W-1:0]   bar_cnt;

    logic               in_range;
    logic               vs_rise;
    logic [ADDR_W-1:0]  base_next;
    logic [ADDR_W-1:0]  addr_next;
    logic [2:0]         idx_cur;
    logic [CNT_W-1:0]   cnt_cur;
    logic [2:0]         idx_next;
    logic [CNT_W-1:0]   cnt_next;
    logic [RGB_W-1:0]   pat_word;
    logic [RGB_W-1:0]   rgb;

    // Index 0 is the newest entry; index L-1 lines up with mem_data.
    logic [L-1:0]       hs_sr;
    logic [L-1:0]       vs_sr;
    logic [L-1:0]       blank_sr;
    logic [L-1:0]       range_sr;
    logic [L-1:0]       rd_sr;
    mode_t              mode_sr [L];
    logic [RGB_W-1:0]   pat_sr  [L];

    assign vs_rise  = vs_in & ~vs_sr[0];
    assign in_range = blank_n_in && (pixel_h < H_VIS) && (pixel_v < V_VIS);

    // Running line base: add one stride per new line, no multiplier.
    always_comb begin
        base_next = line_base;
        if (pixel_v == 11'd0) begin
            base_next = '0;
        end else if (pixel_v != v_prev) begin
            base_next = line_base + H_STRIDE;
        end
        addr_next = base_next + ADDR_W'(pixel_h);
    end

    // Colour-bar tracking: restart at column 0, last bar takes the remainder.
    always_comb begin
        idx_cur  = (pixel_h == 11'd0) ? 3'd0 : bar_idx;
        cnt_cur  = (pixel_h == 11'd0) ? '0 : bar_cnt;
        idx_next = idx_cur;
        cnt_next = cnt_cur;
        if (idx_cur != 3'd7) begin
            if (cnt_cur == BAR_LAST) begin
                idx_next = idx_cur + 3'd1;
                cnt_next = '0;
            end else begin
                cnt_next = cnt_cur + CNT_W'(1);
            end
        end
    end

    // Test-pattern colour for the incoming coordinate.
    always_comb begin
        pat_word = '0;
        unique case (active_sel)
            MODE_BARS: pat_word = {{COLOR_W{~idx_cur[2]}},
                                   {COLOR_W{~idx_cur[1]}},
                                   {COLOR_W{~idx_cur[0]}}};
            MODE_CHECK: pat_word = {RGB_W{pixel_h[4] ^ pixel_v[4]}};
            MODE_WHITE: pat_word = {RGB_W{1'b1}};
            default:    pat_word = '0;
        endcase
    end

    // Stage 0 state: address, line tracking, bar counters, frame mode.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            v_prev     <= '0;
            line_base  <= '0;
            mem_addr   <= '0;
            bar_idx    <= '0;
            bar_cnt    <= '0;
            active_sel <= MODE_FB;
        end else begin
            v_prev    <= pixel_v;
            line_base <= base_next;
            bar_idx   <= idx_next;
            bar_cnt   <= cnt_next;
            if (in_range) begin
                mem_addr <= addr_next;
            end
            if (vs_rise) begin
                active_sel <= mode_t'(pattern_sel);
            end
        end
    end

    // Delay lines carrying timing, mode and pattern alongside the RAM read.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            hs_sr       <= '0;
            vs_sr       <= '0;
            blank_sr    <= '0;
            range_sr    <= '0;
            rd_sr       <= '0;
            frame_start <= 1'b0;
            for (int i = 0; i < L; i++) begin
                mode_sr[i] <= MODE_FB;
                pat_sr[i]  <= '0;
            end
        end else begin
            hs_sr       <= {hs_sr[L-2:0], hs_in};
            vs_sr       <= {vs_sr[L-2:0], vs_in};
            blank_sr    <= {blank_sr[L-2:0], blank_n_in};
            range_sr    <= {range_sr[L-2:0], in_range};
            rd_sr       <= {rd_sr[L-2:0], in_range && (active_sel == MODE_FB)};
            frame_start <= vs_sr[L-2] & ~vs_sr[L-1];
            mode_sr[0]  <= active_sel;
            pat_sr[0]   <= pat_word;
            for (int i = 1; i < L; i++) begin
                mode_sr[i] <= mode_sr[i-1];
                pat_sr[i]  <= pat_sr[i-1];
            end
        end
    end

    // Final colour select; the RAM output register acts as the data register.
    always_comb begin
        rgb = '0;
        if (blank_sr[L-1] && range_sr[L-1]) begin
            if (mode_sr[L-1] == MODE_FB) begin
                if (rd_sr[L-1]) begin
                    rgb = mem_data;
                end
            end else begin
                rgb = pat_sr[L-1];
            end
        end
    end

    assign mem_rd      = rd_sr[0];
    assign vga_r       = rgb[3*COLOR_W-1:2*COLOR_W];
    assign vga_g       = rgb[2*COLOR_W-1:COLOR_W];
    assign vga_b       = rgb[COLOR_W-1:0];
    assign vga_blank_n = blank_sr[L-1];
    assign vga_hs      = hs_sr[L-1];
    assign vga_vs      = vs_sr[L-1];

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench for vga_pixel_fetch: vector tables for the pixel path
// and hand-written sequences for reset, mode switching and frame_start.
module tb_vga_pixel_fetch;

    logic        vga_clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] pixel_h = '0;
    logic [10:0] pixel_v = '0;
    logic        blank_n_in = 1'b0;
    logic        hs_in = 1'b0;
    logic        vs_in = 1'b0;
    logic [1:0]  pattern_sel = '0;
    logic [18:0] mem_addr;
    logic        mem_rd;
    logic [23:0] mem_data = '0;
    logic [23:0] ram_q1 = '0;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        vga_blank_n, vga_hs, vga_vs, frame_start;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [10:0] h;
        logic [10:0] v;
        logic        blank;
        logic        hs;
        logic        chk_addr;
        logic [18:0] addr;
        logic        rd;
        logic [23:0] rgb;
    } vec_t;

    typedef struct {
        int          h;
        logic [23:0] rgb;
    } pt_t;

    vec_t tbl[$];

    vga_pixel_fetch dut (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .pixel_h     (pixel_h),
        .pixel_v     (pixel_v),
        .blank_n_in  (blank_n_in),
        .hs_in       (hs_in),
        .vs_in       (vs_in),
        .pattern_sel (pattern_sel),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_blank_n (vga_blank_n),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .frame_start (frame_start)
    );

    always #5 vga_clk = ~vga_clk;

    function automatic logic [23:0] ram_word(input logic [18:0] a);
        if (a == 19'd1605) return 24'h123456;
        return {a[7:0], a[15:8] ^ 8'h3C, 8'hC3};
    endfunction

    // Two-cycle synchronous RAM; garbage on cycles without a read.
    always @(posedge vga_clk) begin
        ram_q1   <= mem_rd ? ram_word(mem_addr) : 24'hA5A5A5;
        mem_data <= ram_q1;
    end

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int h, input int v, input bit b,
                                input bit hs, input bit ca, input int addr,
                                input bit rd, input logic [23:0] rgb);
        vec_t r;
        r.h = 11'(h);
        r.v = 11'(v);
        r.blank = b;
        r.hs = hs;
        r.chk_addr = ca;
        r.addr = 19'(addr);
        r.rd = rd;
        r.rgb = rgb;
        return r;
    endfunction

    task automatic run_table(input string tag);
        int n;
        n = tbl.size();
        for (int i = 0; i < n + 2; i++) begin
            if (i < n) begin
                pixel_h    = tbl[i].h;
                pixel_v    = tbl[i].v;
                blank_n_in = tbl[i].blank;
                hs_in      = tbl[i].hs;
            end else begin
                blank_n_in = 1'b0;
                hs_in      = 1'b0;
            end
            tick();
            if (i < n) begin
                check($sformatf("%s[%0d] rd", tag, i), 64'(mem_rd),
                      64'(tbl[i].rd));
                if (tbl[i].chk_addr)
                    check($sformatf("%s[%0d] addr", tag, i),
                          64'(mem_addr), 64'(tbl[i].addr));
            end
            if (i >= 2) begin
                check($sformatf("%s[%0d] out", tag, i - 2),
                      64'({vga_r, vga_g, vga_b, vga_blank_n, vga_hs}),
                      64'({tbl[i-2].rgb, tbl[i-2].blank, tbl[i-2].hs}));
            end
        end
        tbl.delete();
    endtask

    task automatic vs_pulse();
        blank_n_in = 1'b0;
        vs_in = 1'b1;
        repeat (4) tick();
        vs_in = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        pt_t pts[6];
        bit  rd_seen;

        // Reset state
        repeat (2) tick();
        check("reset state",
              64'({mem_addr, mem_rd, vga_r, vga_g, vga_b, vga_blank_n,
                   vga_hs, vga_vs, frame_start}), 64'd0);

        // Fill the pipeline, then reset mid-line
        reset = 1'b0;
        blank_n_in = 1'b1;
        hs_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pixel_h = 11'(i);
            tick();
        end
        reset = 1'b1;
        #1;
        check("mid-line reset",
              64'({mem_addr, mem_rd, vga_r, vga_g, vga_b, vga_blank_n,
                   vga_hs, vga_vs, frame_start}), 64'd0);
        blank_n_in = 1'b0;
        pixel_h = '0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("hs refill c1", 64'(vga_hs), 64'd0);
        tick();
        check("hs refill c2", 64'(vga_hs), 64'd0);
        tick();
        check("hs refill c3", 64'(vga_hs), 64'd1);
        hs_in = 1'b0;
        repeat (3) tick();

        // Framebuffer mode
        tbl.push_back(mk(0,   0,   1, 0, 1, 0,    1, 24'h003CC3));
        tbl.push_back(mk(1,   0,   1, 1, 1, 1,    1, 24'h013CC3));
        tbl.push_back(mk(5,   1,   1, 0, 1, 805,  1, 24'h253FC3));
        tbl.push_back(mk(5,   2,   1, 1, 1, 1605, 1, 24'h123456));
        tbl.push_back(mk(6,   2,   1, 0, 1, 1606, 1, 24'h463AC3));
        tbl.push_back(mk(800, 2,   1, 0, 1, 1606, 0, 24'h000000));
        tbl.push_back(mk(10,  2,   0, 1, 1, 1606, 0, 24'h000000));
        tbl.push_back(mk(799, 2,   1, 0, 1, 2399, 1, 24'h5F35C3));
        tbl.push_back(mk(3,   0,   1, 0, 1, 3,    1, 24'h033CC3));
        tbl.push_back(mk(3,   480, 1, 1, 1, 3,    0, 24'h000000));
        run_table("fb");

        // Mode change mid-frame has no effect yet
        pattern_sel = 2'd1;
        tbl.push_back(mk(0, 0, 1, 0, 1, 0, 1, 24'h003CC3));
        run_table("midframe");

        // vs rise: frame_start and vga_vs together, three cycles later
        blank_n_in = 1'b0;
        vs_in = 1'b1;
        tick();
        check("vs c1", 64'({vga_vs, frame_start}), 64'b00);
        tick();
        check("vs c2", 64'({vga_vs, frame_start}), 64'b00);
        tick();
        check("vs c3", 64'({vga_vs, frame_start}), 64'b11);
        tick();
        check("vs c4", 64'({vga_vs, frame_start}), 64'b10);
        vs_in = 1'b0;
        repeat (4) tick();

        // Colour bars sweep over one line
        pts[0] = '{0,   24'hFFFFFF};
        pts[1] = '{99,  24'hFFFFFF};
        pts[2] = '{100, 24'hFFFF00};
        pts[3] = '{250, 24'hFF00FF};
        pts[4] = '{799, 24'h000000};
        pts[5] = '{800, 24'h000000};
        rd_seen = 1'b0;
        for (int i = 0; i <= 802; i++) begin
            if (i <= 800) begin
                pixel_h = 11'(i);
                pixel_v = '0;
                blank_n_in = 1'b1;
            end else begin
                blank_n_in = 1'b0;
            end
            tick();
            if (mem_rd) rd_seen = 1'b1;
            for (int k = 0; k < 6; k++) begin
                if (i - 2 == pts[k].h)
                    check($sformatf("bars h=%0d", pts[k].h),
                          64'({vga_r, vga_g, vga_b}), 64'(pts[k].rgb));
            end
        end
        check("bars no rd", 64'(rd_seen), 64'd0);

        // Checkerboard
        pattern_sel = 2'd2;
        vs_pulse();
        tbl.push_back(mk(16, 0,  1, 0, 0, 0, 0, 24'hFFFFFF));
        tbl.push_back(mk(16, 16, 1, 1, 0, 0, 0, 24'h000000));
        tbl.push_back(mk(0,  0,  1, 0, 0, 0, 0, 24'h000000));
        tbl.push_back(mk(0,  16, 1, 1, 0, 0, 0, 24'hFFFFFF));
        tbl.push_back(mk(31, 0,  1, 0, 0, 0, 0, 24'hFFFFFF));
        tbl.push_back(mk(32, 0,  1, 0, 0, 0, 0, 24'h000000));
        run_table("check");

        // Solid white, then a mid-frame select change that must not apply
        pattern_sel = 2'd3;
        vs_pulse();
        pattern_sel = 2'd0;
        tbl.push_back(mk(5,   5, 1, 0, 0, 0, 0, 24'hFFFFFF));
        tbl.push_back(mk(800, 5, 1, 1, 0, 0, 0, 24'h000000));
        tbl.push_back(mk(7,   5, 0, 0, 0, 0, 0, 24'h000000));
        tbl.push_back(mk(1,   5, 1, 0, 0, 0, 0, 24'hFFFFFF));
        run_table("white");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
